// File: rtl/dual_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dual_pkg
// Description : Shared opcode/funct constants and predecode record for the
//               dual-issue front end.
// Revision    : 1.0 - initial release
// ============================================================================
package dual_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_LUI    = 6'h0F;

  // R-type function codes
  localparam logic [5:0] FN_SLL    = 6'h00;
  localparam logic [5:0] FN_SRL    = 6'h02;
  localparam logic [5:0] FN_SRA    = 6'h03;
  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_JALR   = 6'h09;
  localparam logic [5:0] FN_MFHI   = 6'h10;
  localparam logic [5:0] FN_MTHI   = 6'h11;
  localparam logic [5:0] FN_MFLO   = 6'h12;
  localparam logic [5:0] FN_MTLO   = 6'h13;
  localparam logic [5:0] FN_MULT   = 6'h18;
  localparam logic [5:0] FN_MULTU  = 6'h19;
  localparam logic [5:0] FN_DIV    = 6'h1A;
  localparam logic [5:0] FN_DIVU   = 6'h1B;

  localparam logic [4:0] REG_RA    = 5'd31;

  typedef struct packed {
    logic       is_branch;
    logic       is_mem;
    logic       is_hilo;
    logic [4:0] dest;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       reads_rs;
    logic       reads_rt;
  } predecode_t;

endpackage
`default_nettype wire

// File: rtl/inst_predecode.sv
`default_nettype none
// ============================================================================
// Module      : inst_predecode
// Description : Combinational classification of one instruction for the
//               pairing checks (control flow, memory, HI/LO, register use).
// Revision    : 1.0 - initial release
// ============================================================================
module inst_predecode
  import dual_pkg::*;
#(
  parameter int INST_W = 32
) (
  input  logic [INST_W-1:0] inst,
  output predecode_t        pd
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign op = inst[31:26];
  assign rs = inst[25:21];
  assign rt = inst[20:16];
  assign rd = inst[15:11];
  assign fn = inst[5:0];

  // Immediate/shamt fields play no part in pairing.
  logic unused_fields;
  assign unused_fields = ^inst;

  // Decode class, destination and source usage from opcode/funct.
  always_comb begin
    pd          = '0;
    pd.rs       = rs;
    pd.rt       = rt;
    case (op)
      OP_RTYPE: begin
        pd.dest     = rd;
        pd.reads_rs = 1'b1;
        pd.reads_rt = 1'b1;
        case (fn)
          FN_SLL, FN_SRL, FN_SRA: pd.reads_rs = 1'b0;
          FN_JR: begin
            pd.is_branch = 1'b1;
            pd.dest      = 5'd0;
            pd.reads_rt  = 1'b0;
          end
          FN_JALR: begin
            pd.is_branch = 1'b1;
            pd.reads_rt  = 1'b0;
          end
          FN_MFHI, FN_MFLO: begin
            pd.is_hilo  = 1'b1;
            pd.reads_rs = 1'b0;
            pd.reads_rt = 1'b0;
          end
          FN_MTHI, FN_MTLO: begin
            pd.is_hilo  = 1'b1;
            pd.dest     = 5'd0;
            pd.reads_rt = 1'b0;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            pd.is_hilo = 1'b1;
            pd.dest    = 5'd0;
          end
          default: ;
        endcase
      end
      OP_REGIMM: begin
        pd.is_branch = 1'b1;
        pd.reads_rs  = 1'b1;
      end
      OP_J:   pd.is_branch = 1'b1;
      OP_JAL: begin
        pd.is_branch = 1'b1;
        pd.dest      = REG_RA;
      end
      OP_BEQ, OP_BNE: begin
        pd.is_branch = 1'b1;
        pd.reads_rs  = 1'b1;
        pd.reads_rt  = 1'b1;
      end
      OP_BLEZ, OP_BGTZ: begin
        pd.is_branch = 1'b1;
        pd.reads_rs  = 1'b1;
      end
      default: begin
        if (op[5:3] == 3'b001) begin
          // I-type ALU; lui has no register source
          pd.dest     = rt;
          pd.reads_rs = (op != OP_LUI);
        end else if (op[5:3] == 3'b100) begin
          // loads
          pd.is_mem   = 1'b1;
          pd.dest     = rt;
          pd.reads_rs = 1'b1;
        end else if (op[5:3] == 3'b101) begin
          // stores
          pd.is_mem   = 1'b1;
          pd.reads_rs = 1'b1;
          pd.reads_rt = 1'b1;
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : issue_scheduler
// Description : Circular instruction queue between fetch and decode that
//               issues up to two instructions per cycle to the master and
//               slave decode lanes under pairing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_scheduler
  import dual_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int INST_W = 32,
  parameter int PC_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               push_valid,
  input  logic [INST_W-1:0]        push_inst0,
  input  logic [INST_W-1:0]        push_inst1,
  input  logic [PC_W-1:0]          push_pc0,
  input  logic [PC_W-1:0]          push_pc1,
  output logic                     fetch_ready,
  input  logic                     flush,
  input  logic                     stall_master,
  input  logic                     stall_slave,
  output logic                     issue0_valid,
  output logic [INST_W-1:0]        issue0_inst,
  output logic [PC_W-1:0]          issue0_pc,
  output logic                     issue1_valid,
  output logic [INST_W-1:0]        issue1_inst,
  output logic [PC_W-1:0]          issue1_pc,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int AW = $clog2(DEPTH);

  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [PC_W-1:0]   mem_pc   [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;
  logic [AW-1:0] head_p1;
  logic [AW-1:0] tail_p1;
  logic          push_en;
  logic [1:0]    npush;
  logic [1:0]    npop;
  logic [AW:0]   count_next;

  predecode_t pd0;
  predecode_t pd1;

  assign head_p1     = head + AW'(1);
  assign tail_p1     = tail + AW'(1);
  assign q_count     = count;
  assign fetch_ready = (count <= (AW+1)'(DEPTH-2));
  assign push_en     = fetch_ready && !flush;
  assign npush       = push_en ? ({1'b0, push_valid[0]} + {1'b0, push_valid[1]}) : 2'd0;

  assign issue0_inst = mem_inst[head];
  assign issue0_pc   = mem_pc[head];
  assign issue1_inst = mem_inst[head_p1];
  assign issue1_pc   = mem_pc[head_p1];

  inst_predecode #(.INST_W(INST_W)) u_pd0 (.inst(issue0_inst), .pd(pd0));
  inst_predecode #(.INST_W(INST_W)) u_pd1 (.inst(issue1_inst), .pd(pd1));

  // The master instruction's source fields are irrelevant to pairing.
  logic unused_pd0;
  assign unused_pd0 = ^{pd0.rs, pd0.rt, pd0.reads_rs, pd0.reads_rt};

  // Pairing decision for the slave slot and the resulting pop count.
  always_comb begin
    logic raw;
    logic waw;
    raw = (pd0.dest != 5'd0) &&
          ((pd1.reads_rs && (pd1.rs == pd0.dest)) ||
           (pd1.reads_rt && (pd1.rt == pd0.dest)));
    waw = (pd0.dest != 5'd0) && (pd0.dest == pd1.dest);
    issue0_valid = (count >= (AW+1)'(1));
    issue1_valid = (count >= (AW+1)'(2)) && !stall_slave &&
                   !pd1.is_branch && !pd0.is_branch &&
                   !(pd0.is_mem && pd1.is_mem) &&
                   !(pd0.is_hilo && pd1.is_hilo) &&
                   !raw && !waw;
    npop = stall_master ? 2'd0 : ({1'b0, issue0_valid} + {1'b0, issue1_valid});
    count_next = count + (AW+1)'(npush) - (AW+1)'(npop);
  end

  // Queue pointers and occupancy; flush empties the queue on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(npop);
      tail  <= tail + AW'(npush);
      count <= count_next;
    end
  end

  // Queue storage writes; contents are not reset.
  always_ff @(posedge clk) begin
    if (push_en && push_valid[0]) begin
      mem_inst[tail] <= push_inst0;
      mem_pc[tail]   <= push_pc0;
    end
    if (push_en && push_valid[1]) begin
      mem_inst[tail_p1] <= push_inst1;
      mem_pc[tail_p1]   <= push_pc1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_scheduler
// Description : Directed self-checking bench for issue_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_scheduler;

  localparam int DEPTH  = 8;
  localparam int INST_W = 32;
  localparam int PC_W   = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        push_valid;
  logic [INST_W-1:0] push_inst0, push_inst1;
  logic [PC_W-1:0]   push_pc0, push_pc1;
  logic              fetch_ready;
  logic              flush, stall_master, stall_slave;
  logic              issue0_valid, issue1_valid;
  logic [INST_W-1:0] issue0_inst, issue1_inst;
  logic [PC_W-1:0]   issue0_pc, issue1_pc;
  logic [3:0]        q_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  issue_scheduler #(.DEPTH(DEPTH), .INST_W(INST_W), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid),
    .push_inst0(push_inst0), .push_inst1(push_inst1),
    .push_pc0(push_pc0), .push_pc1(push_pc1),
    .fetch_ready(fetch_ready),
    .flush(flush), .stall_master(stall_master), .stall_slave(stall_slave),
    .issue0_valid(issue0_valid), .issue0_inst(issue0_inst), .issue0_pc(issue0_pc),
    .issue1_valid(issue1_valid), .issue1_inst(issue1_inst), .issue1_pc(issue1_pc),
    .q_count(q_count)
  );

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] p0,
                      input logic [31:0] i1, input logic [31:0] p1);
    push_valid = v;
    push_inst0 = i0;
    push_pc0   = p0;
    push_inst1 = i1;
    push_pc1   = p1;
  endtask

  task automatic idle();
    push_valid = 2'b00;
  endtask

  logic [31:0] add123, sub456, or415, sub145, lw, sw, mult, mflo, beq, add345, jmp;

  initial begin
    add123 = rtype(5'd2, 5'd3, 5'd1, 6'h20);
    sub456 = rtype(5'd5, 5'd6, 5'd4, 6'h22);
    or415  = rtype(5'd1, 5'd5, 5'd4, 6'h25);
    sub145 = rtype(5'd4, 5'd5, 5'd1, 6'h22);
    lw     = itype(6'h23, 5'd9, 5'd8, 16'h0000);
    sw     = itype(6'h2B, 5'd11, 5'd10, 16'h0004);
    mult   = rtype(5'd12, 5'd13, 5'd0, 6'h18);
    mflo   = rtype(5'd0, 5'd0, 5'd14, 6'h12);
    beq    = itype(6'h04, 5'd1, 5'd2, 16'h0010);
    add345 = rtype(5'd4, 5'd5, 5'd3, 6'h20);
    jmp    = {6'h02, 26'h0000010};

    rst = 1'b1; flush = 1'b0; stall_master = 1'b0; stall_slave = 1'b0;
    push(2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_count", 32'(q_count), 32'd0);
    check("rst_ready", 32'(fetch_ready), 32'd1);
    check("rst_v0", 32'(issue0_valid), 32'd0);
    check("rst_v1", 32'(issue1_valid), 32'd0);

    // Independent pair dual-issues (entries 0,1)
    push(2'b11, add123, 32'h1000, sub456, 32'h1004); tick; idle();
    check("dual_count", 32'(q_count), 32'd2);
    check("dual_v0", 32'(issue0_valid), 32'd1);
    check("dual_v1", 32'(issue1_valid), 32'd1);
    check("dual_inst0", issue0_inst, add123);
    check("dual_pc0", issue0_pc, 32'h1000);
    check("dual_pc1", issue1_pc, 32'h1004);
    tick;
    check("dual_drain", 32'(q_count), 32'd0);
    check("dual_drain_v0", 32'(issue0_valid), 32'd0);

    // RAW pair (entries 2,3)
    push(2'b11, add123, 32'h1010, or415, 32'h1014); tick; idle();
    check("raw_v0", 32'(issue0_valid), 32'd1);
    check("raw_v1", 32'(issue1_valid), 32'd0);
    tick;
    check("raw_count", 32'(q_count), 32'd1);
    check("raw_inst0", issue0_inst, or415);
    check("raw_pc0", issue0_pc, 32'h1014);
    tick;

    // WAW pair (entries 4,5)
    push(2'b11, add123, 32'h1020, sub145, 32'h1024); tick; idle();
    check("waw_v1", 32'(issue1_valid), 32'd0);
    tick;
    check("waw_count", 32'(q_count), 32'd1);
    tick;

    // Two memory ops (entries 6,7)
    push(2'b11, lw, 32'h1030, sw, 32'h1034); tick; idle();
    check("mem_v1", 32'(issue1_valid), 32'd0);
    tick;
    check("mem_inst0", issue0_inst, sw);
    check("mem_count", 32'(q_count), 32'd1);
    tick;

    // Two HI/LO ops (entries 0,1 after wrap)
    push(2'b11, mult, 32'h1040, mflo, 32'h1044); tick; idle();
    check("hilo_v1", 32'(issue1_valid), 32'd0);
    tick;
    check("hilo_inst0", issue0_inst, mflo);
    tick;

    // Branch at head keeps delay slot for next cycle (entries 2,3)
    push(2'b11, beq, 32'h1050, add345, 32'h1054); tick; idle();
    check("br_head_v0", 32'(issue0_valid), 32'd1);
    check("br_head_v1", 32'(issue1_valid), 32'd0);
    tick;
    check("br_slot_pc0", issue0_pc, 32'h1054);
    tick;

    // Jump in slave position (entries 4,5)
    push(2'b11, add123, 32'h1060, jmp, 32'h1064); tick; idle();
    check("br_slave_v1", 32'(issue1_valid), 32'd0);
    tick;
    check("br_j_inst0", issue0_inst, jmp);
    check("br_j_v1", 32'(issue1_valid), 32'd0);
    tick;

    // Slave stall suppresses slot 1 (entries 6,7)
    stall_slave = 1'b1;
    push(2'b11, add123, 32'h1070, sub456, 32'h1074); tick; idle();
    check("sslv_v1", 32'(issue1_valid), 32'd0);
    tick;
    check("sslv_count", 32'(q_count), 32'd1);
    stall_slave = 1'b0;
    tick;

    // Single push/pop to place head at 1 so head+1 later wraps
    push(2'b01, add123, 32'h2000, 32'd0, 32'd0); tick; idle();
    check("single_count", 32'(q_count), 32'd1);
    tick;

    // Fill to DEPTH while stalled
    stall_master = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(2'b11, rtype(5'd0, 5'd0, 5'(10 + 2*k), 6'h20), 32'h3000 + 32'(8*k),
                  rtype(5'd0, 5'd0, 5'(11 + 2*k), 6'h20), 32'h3004 + 32'(8*k));
      tick;
      check("fill_count", 32'(q_count), 32'(2*k + 2));
    end
    check("full_ready", 32'(fetch_ready), 32'd0);
    push(2'b11, 32'hDEAD_BEEF, 32'h9000, 32'hDEAD_BEEF, 32'h9004); tick; idle();
    check("full_hold", 32'(q_count), 32'd8);
    check("stall_pc0", issue0_pc, 32'h3000);
    check("stall_pc1", issue1_pc, 32'h3004);
    stall_master = 1'b0;
    #1;
    check("release_v1", 32'(issue1_valid), 32'd1);
    tick;
    check("drain1_count", 32'(q_count), 32'd6);
    check("drain1_ready", 32'(fetch_ready), 32'd1);
    check("drain1_pc0", issue0_pc, 32'h3008);
    tick;
    check("drain2_pc0", issue0_pc, 32'h3010);
    tick;
    check("wrap_count", 32'(q_count), 32'd2);
    check("wrap_pc0", issue0_pc, 32'h3018);
    check("wrap_pc1", issue1_pc, 32'h301C);
    check("wrap_v1", 32'(issue1_valid), 32'd1);
    tick;
    check("wrap_drain", 32'(q_count), 32'd0);

    // Flush with a simultaneous push at occupancy 5
    stall_master = 1'b1;
    push(2'b11, add123, 32'h4000, sub456, 32'h4004); tick;
    push(2'b11, add123, 32'h4008, sub456, 32'h400C); tick;
    push(2'b01, add123, 32'h4010, 32'd0, 32'd0); tick;
    check("pre_flush", 32'(q_count), 32'd5);
    flush = 1'b1;
    push(2'b11, add123, 32'h4020, sub456, 32'h4024); tick;
    flush = 1'b0; idle();
    check("flush_count", 32'(q_count), 32'd0);
    check("flush_v0", 32'(issue0_valid), 32'd0);
    check("flush_v1", 32'(issue1_valid), 32'd0);
    check("flush_ready", 32'(fetch_ready), 32'd1);

    // Asynchronous reset between clock edges
    push(2'b11, add123, 32'h5000, sub456, 32'h5004); tick; idle();
    check("pre_rst_count", 32'(q_count), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("arst_count", 32'(q_count), 32'd0);
    check("arst_v0", 32'(issue0_valid), 32'd0);
    check("arst_v1", 32'(issue1_valid), 32'd0);
    check("arst_ready", 32'(fetch_ready), 32'd1);
    #1 rst = 1'b0;
    stall_master = 1'b0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
